// File: rtl/latq_bank_read_port.sv
// Read sequencer for a latch-based register bank: waits for the addressed row's
// enable to be low and settled, captures the row into a flop, returns it with valid/ack.
module latq_bank_read_port #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int SETTLE_CYC = 1,
  parameter int STALL_MAX  = 15
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RD_REQ,
  input  logic [AW-1:0]          RD_ADDR,
  output logic                   RD_READY,
  output logic                   RD_VALID,
  input  logic                   RD_ACK,
  output logic [WIDTH-1:0]       RD_DATA,
  output logic                   RD_ERR,
  input  logic [DEPTH-1:0]       ROW_E,
  input  logic [DEPTH*WIDTH-1:0] ROW_Q
);
  typedef enum logic [1:0] {IDLE, WAIT, SETTLE, RESP} state_t;

  state_t           state, state_nx;
  logic [AW-1:0]    addr, addr_nx, sel_addr;
  logic [7:0]       stall_cnt, stall_nx;
  logic [2:0]       settle_cnt, settle_nx;
  logic [WIDTH-1:0] data_nx, q_sel;
  logic             err_nx, e_sel, in_range;
  logic             live;
  logic [WIDTH-1:0] rows [DEPTH];

  for (genvar r = 0; r < DEPTH; r++) begin : g_row
    assign rows[r] = ROW_Q[r*WIDTH +: WIDTH];
  end

  // Row select by compare rather than indexing, so an address >= DEPTH never
  // reaches ROW_Q and simply reports not-in-range.
  assign sel_addr = (state == IDLE) ? RD_ADDR : addr;
  always_comb begin
    e_sel    = 1'b0;
    q_sel    = '0;
    in_range = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      if (sel_addr == AW'(r)) begin
        e_sel    = ROW_E[r];
        q_sel    = rows[r];
        in_range = 1'b1;
      end
    end
  end

  assign RD_READY = live && (state == IDLE);
  assign RD_VALID = (state == RESP);

  always_comb begin
    state_nx  = state;
    addr_nx   = addr;
    stall_nx  = stall_cnt;
    settle_nx = settle_cnt;
    data_nx   = RD_DATA;
    err_nx    = RD_ERR;
    case (state)
      IDLE: if (RD_REQ && live) begin
        addr_nx   = RD_ADDR;
        stall_nx  = '0;
        settle_nx = '0;
        if (!in_range) begin
          state_nx = RESP;
          data_nx  = '0;
          err_nx   = 1'b1;
        end else if (e_sel) state_nx = WAIT;
        else                state_nx = SETTLE;
      end
      WAIT: if (e_sel) begin
        if (stall_cnt >= 8'(STALL_MAX-1)) begin
          state_nx = RESP;
          data_nx  = '0;
          err_nx   = 1'b1;
        end else if (stall_cnt != 8'hff) stall_nx = stall_cnt + 8'd1;
      end else begin
        state_nx  = SETTLE;
        settle_nx = '0;
      end
      SETTLE: if (e_sel) state_nx = WAIT;   // stall budget keeps accumulating
      else if (settle_cnt >= 3'(SETTLE_CYC-1)) begin
        state_nx = RESP;
        data_nx  = q_sel;
        err_nx   = 1'b0;
      end else if (settle_cnt != 3'h7) settle_nx = settle_cnt + 3'd1;
      RESP: if (RD_ACK) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      addr       <= '0;
      stall_cnt  <= '0;
      settle_cnt <= '0;
      RD_DATA    <= '0;
      RD_ERR     <= 1'b0;
      live       <= 1'b0;
    end else begin
      state      <= state_nx;
      addr       <= addr_nx;
      stall_cnt  <= stall_nx;
      settle_cnt <= settle_nx;
      RD_DATA    <= data_nx;
      RD_ERR     <= err_nx;
      live       <= 1'b1;
    end
  end
endmodule

// File: tb/tb_latq_bank_read_port.sv
// Directed bench: three parameterisations share one stimulus bus; each section
// resets and checks the instance whose parameters it exercises.
module tb_latq_bank_read_port;
  logic        CLK = 1'b0;
  logic        RST;
  logic        RD_REQ, RD_ACK;
  logic [2:0]  RD_ADDR;
  logic [7:0]  ROW_E;
  logic [63:0] ROW_Q;

  logic       a_ready, a_valid, a_err;
  logic [7:0] a_data;
  logic       b_ready, b_valid, b_err;
  logic [7:0] b_data;
  logic       c_ready, c_valid, c_err;
  logic [7:0] c_data;

  int n_chk = 0;
  int n_pass = 0;
  int n;

  always #5 CLK = ~CLK;

  latq_bank_read_port u_a (
    .CLK(CLK), .RST(RST), .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_READY(a_ready),
    .RD_VALID(a_valid), .RD_ACK(RD_ACK), .RD_DATA(a_data), .RD_ERR(a_err),
    .ROW_E(ROW_E), .ROW_Q(ROW_Q));

  latq_bank_read_port #(.SETTLE_CYC(3)) u_b (
    .CLK(CLK), .RST(RST), .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_READY(b_ready),
    .RD_VALID(b_valid), .RD_ACK(RD_ACK), .RD_DATA(b_data), .RD_ERR(b_err),
    .ROW_E(ROW_E), .ROW_Q(ROW_Q));

  latq_bank_read_port #(.DEPTH(6)) u_c (
    .CLK(CLK), .RST(RST), .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_READY(c_ready),
    .RD_VALID(c_valid), .RD_ACK(RD_ACK), .RD_DATA(c_data), .RD_ERR(c_err),
    .ROW_E(ROW_E[5:0]), .ROW_Q(ROW_Q[47:0]));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #2;
    RST = 1'b0;
    tick();
  endtask

  task automatic set_row(input int r, input logic [7:0] v);
    ROW_Q[r*8 +: 8] = v;
  endtask

  initial begin
    logic [7:0] exp_row [8];
    int addrs [3];
    RST = 1'b1; RD_REQ = 1'b0; RD_ACK = 1'b0; RD_ADDR = '0; ROW_E = '0; ROW_Q = '0;
    exp_row = '{8'h10, 8'h77, 8'h11, 8'hA5, 8'h42, 8'h3C, 8'h66, 8'h99};
    for (int r = 0; r < 8; r++) set_row(r, exp_row[r]);

    // reset state
    tick(); tick();
    chk("rst_ready", a_ready, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_data",  a_data,  0);
    chk("rst_err",   a_err,   0);
    RST = 1'b0;
    #1;
    chk("rel_ready_before_edge", a_ready, 0);
    tick();
    chk("rel_ready_after_edge", a_ready, 1);

    // closed row, SETTLE_CYC=1, ack held
    RD_REQ = 1'b1; RD_ADDR = 3'd3; RD_ACK = 1'b1;
    tick();
    RD_REQ = 1'b0;
    chk("t2_valid_T", a_valid, 0);
    chk("t2_ready_T", a_ready, 0);
    tick();
    chk("t2_valid_T1", a_valid, 1);
    chk("t2_data",     a_data,  8'hA5);
    chk("t2_err",      a_err,   0);
    tick();
    chk("t2_valid_T2", a_valid, 0);
    chk("t2_ready_T2", a_ready, 1);

    // row 5 held open for 4 cycles after accept
    do_reset();
    RD_ACK = 1'b0; ROW_E = 8'h20; RD_REQ = 1'b1; RD_ADDR = 3'd5;
    tick();
    RD_REQ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_no_valid_while_open", a_valid, 0);
    end
    ROW_E = 8'h00;
    n = 0;
    while (!a_valid && n < 20) begin tick(); n++; end
    chk("t3_edges_after_close", n, 2);
    chk("t3_data", a_data, 8'h3C);
    chk("t3_err",  a_err,  0);
    RD_ACK = 1'b1;
    tick();
    RD_ACK = 1'b0;
    chk("t3_valid_after_ack", a_valid, 0);
    chk("t3_data_hold",       a_data,  8'h3C);

    // SETTLE_CYC=3 instance: row 2 reopens during settle
    do_reset();
    ROW_E = 8'h04; RD_REQ = 1'b1; RD_ADDR = 3'd2;
    tick();
    RD_REQ = 1'b0;
    tick();
    ROW_E = 8'h00;
    tick(); tick();
    ROW_E = 8'h04;
    tick();
    chk("t4_no_valid_reopen", b_valid, 0);
    set_row(2, 8'h5E);
    tick();
    ROW_E = 8'h00;
    n = 0;
    while (!b_valid && n < 20) begin tick(); n++; end
    chk("t4_edges_after_close", n, 4);
    chk("t4_data_final", b_data, 8'h5E);
    chk("t4_err",        b_err,  0);
    RD_ACK = 1'b1;
    tick();
    RD_ACK = 1'b0;
    chk("t4_data_hold", b_data, 8'h5E);

    // reset mid-SETTLE on the SETTLE_CYC=3 instance
    RD_REQ = 1'b1; RD_ADDR = 3'd4;
    tick();
    RD_REQ = 1'b0;
    tick();
    RST = 1'b1;
    #1;
    chk("t1_valid_in_rst", b_valid, 0);
    chk("t1_data_in_rst",  b_data,  0);
    chk("t1_err_in_rst",   b_err,   0);
    chk("t1_ready_in_rst", b_ready, 0);
    RST = 1'b0;
    tick();
    chk("t1_ready_after", b_ready, 1);
    n = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (b_valid) n++; end
    chk("t1_no_stale", n, 0);

    // row 1 stuck open -> stall timeout
    do_reset();
    ROW_E = 8'h02; RD_REQ = 1'b1; RD_ADDR = 3'd1;
    tick();
    RD_REQ = 1'b0;
    n = 0;
    while (!a_valid && n < 40) begin tick(); n++; end
    chk("t5_stall_edges", n, 15);
    chk("t5_err",  a_err,  1);
    chk("t5_data", a_data, 0);
    RD_ACK = 1'b1;
    tick();
    RD_ACK = 1'b0;
    ROW_E = 8'h00;

    // DEPTH=6 instance, out-of-range address
    do_reset();
    RD_REQ = 1'b1; RD_ADDR = 3'd7;
    tick();
    RD_REQ = 1'b0;
    chk("t6_valid", c_valid, 1);
    chk("t6_err",   c_err,   1);
    chk("t6_data",  c_data,  0);
    RD_ACK = 1'b1;
    tick();
    chk("t6_ready_after_ack", c_ready, 1);

    // back-to-back with REQ and ACK held high
    do_reset();
    addrs = '{0, 3, 5};
    RD_REQ = 1'b1; RD_ACK = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("b2b_ready_1", a_ready, 1);
      RD_ADDR = 3'(addrs[k]);
      tick();
      chk("b2b_ready_0a", a_ready, 0);
      tick();
      chk("b2b_ready_0b", a_ready, 0);
      chk("b2b_valid", a_valid, 1);
      chk("b2b_data",  a_data,  exp_row[addrs[k]]);
      tick();
    end
    RD_REQ = 1'b0;
    chk("b2b_ready_end", a_ready, 1);
    chk("b2b_valid_end", a_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
